twos_serializer: RTL and testbench

//   Upstream feeder for the serial two's-complement stage.

---
 rtl/twos_serializer.sv | 76 +++++++
 tb/tb_twos_serializer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/twos_serializer.sv
// Parallel-to-serial feeder for the serial two's-complement stage: LSB-first bits,
// each word preceded by a one-cycle clear that restarts the complementer.
module twos_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             t_clk,
    input  logic             r,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_out,
    output logic             ser_clr,
    output logic             ser_valid,
    output logic             ser_last
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0] r_cnt;
    logic             r_alive;
    logic             w_last_bit;
    logic             w_accept;

    assign w_last_bit = (r_state == SHIFT) && (r_cnt == LAST);
    // r_alive keeps din_ready low for the whole cycle in which reset is released.
    assign din_ready  = r_alive && !r && ((r_state == IDLE) || w_last_bit);
    assign w_accept   = din_valid && din_ready;

    assign ser_clr    = (r_state == CLEAR);
    assign ser_valid  = (r_state == SHIFT);
    assign ser_out    = (r_state == SHIFT) && r_shreg[0];
    assign ser_last   = w_last_bit;

    always_ff @(posedge t_clk or posedge r) begin
        if (r) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_alive <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_shreg <= din;
                        r_state <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_cnt   <= '0;
                    r_state <= SHIFT;
                end
                SHIFT: begin
                    if (w_last_bit) begin
                        r_cnt <= '0;
                        if (w_accept) begin
                            r_shreg <= din;
                            r_state <= CLEAR;
                        end else begin
                            r_shreg <= '0;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_shreg <= r_shreg >> 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_twos_serializer.sv
// Bench for twos_serializer: per-cycle comparison against a queue of expected output
// cycles, plus a behavioural complementer fed from ser_out.
module tb_twos_serializer;
    localparam int W = 8;

    logic         t_clk = 1'b0;
    logic         r;
    logic [W-1:0] din;
    logic         din_valid;
    logic         din_ready, ser_out, ser_clr, ser_valid, ser_last;

    twos_serializer #(.WIDTH(W)) dut (
        .t_clk(t_clk), .r(r), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .ser_out(ser_out), .ser_clr(ser_clr), .ser_valid(ser_valid), .ser_last(ser_last)
    );

    always #78 t_clk = ~t_clk;

    typedef struct {
        logic         clr, out, vld, last;
        logic [W-1:0] word;
    } exp_t;

    exp_t         q[$];
    int           tests = 0, fails = 0, cyc = 0;
    bit           m_alive = 0, m_acc = 0;
    logic [W-1:0] acc_word;
    bit           seen;
    int           bitpos;
    logic [W-1:0] yw;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic bit model_ready();
        return m_alive && !r && (q.size() == 0 || (q.size() == 1 && q[0].last));
    endfunction

    // One clock cycle: check at negedge, advance the model at posedge, return #1 later.
    task automatic cycle();
        logic [3:0] e;
        @(negedge t_clk);
        e = (q.size() > 0) ? {q[0].clr, q[0].out, q[0].vld, q[0].last} : 4'b0;
        chk("outs", {28'b0, ser_clr, ser_out, ser_valid, ser_last}, {28'b0, e});
        chk("din_ready", {31'b0, din_ready}, {31'b0, model_ready()});
        // behavioural complementer driven by the DUT's serial stream
        if (r || ser_clr) begin
            seen = 0; bitpos = 0; yw = '0;
        end else if (ser_valid) begin
            if (bitpos < W) yw[bitpos] = ser_out ^ seen;
            seen = seen | ser_out;
            bitpos++;
            if (ser_last && q.size() > 0) begin
                chk("y_word", {24'b0, yw}, {24'b0, W'(0) - q[0].word});
                chk("bit_count", bitpos, W);
            end
        end
        m_acc    = din_valid && model_ready();
        acc_word = din;
        @(posedge t_clk);
        cyc++;
        if (q.size() > 0) void'(q.pop_front());
        if (m_acc) begin
            q.push_back('{1'b1, 1'b0, 1'b0, 1'b0, acc_word});
            for (int j = 0; j < W; j++)
                q.push_back('{1'b0, acc_word[j], 1'b1, j == W - 1, acc_word});
        end
        m_alive = !r;
        #1;
    endtask

    task automatic send(input logic [W-1:0] w, input bit keep);
        bit got = 0;
        din = w; din_valid = 1'b1;
        for (int k = 0; k < 3 * W && !got; k++) begin
            cycle();
            got = m_acc;
        end
        if (!got) chk("accept_timeout", 0, 1);
        if (!keep) din_valid = 1'b0;
    endtask

    initial begin
        int c0;
        r = 1'b0; din = '0; din_valid = 1'b0;
        #2 r = 1'b1;
        #8;
        chk("rst_outs", {ser_clr, ser_out, ser_valid, ser_last}, 0);
        chk("rst_ready", din_ready, 0);
        repeat (2) cycle();
        r = 1'b0;

        // idle with no traffic: ready rises one cycle after release
        repeat (10) cycle();

        // one-shot 8'h06 -> y = 8'hFA
        send(8'h06, 0);
        repeat (11) cycle();

        // back-to-back 8'h01 then 8'h80 with valid held
        send(8'h01, 1);
        c0 = cyc;
        send(8'h80, 0);
        chk("b2b_gap", cyc - c0, W + 1);
        repeat (11) cycle();

        // din churn during the shift of 8'hC3 must not disturb the word
        send(8'hC3, 0);
        repeat (W) begin
            din = W'($urandom); din_valid = 1'($urandom);
            cycle();
        end
        din_valid = 1'b0;
        repeat (4) cycle();

        // all-zero and all-one operands
        send(8'h00, 1);
        send(8'hFF, 0);
        repeat (11) cycle();

        // reset after the 3rd bit of 8'hA5: outputs drop without an edge
        send(8'hA5, 0);
        repeat (4) cycle();
        r = 1'b1;
        q.delete();
        #1;
        chk("midword_outs", {ser_clr, ser_out, ser_valid, ser_last}, 0);
        chk("midword_ready", din_ready, 0);
        repeat (2) cycle();
        r = 1'b0; din = 8'h3C; din_valid = 1'b1;
        cycle();
        chk("release_no_accept", m_acc, 0);
        send(8'h3C, 0);
        repeat (11) cycle();

        // randomized traffic with random gaps and back-to-back runs
        for (int n = 0; n < 30; n++) begin
            if (!din_valid) repeat ($urandom_range(0, 3)) cycle();
            send(W'($urandom), 1'($urandom));
        end
        din_valid = 1'b0;
        repeat (2 * W + 4) cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
